// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared state encoding and sizing constants for the data-memory responder
package pipe_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} memState_t;
   localparam int WORD_BYTES = 4;
   localparam int DEFAULT_DEPTH_WORDS = 256;
   localparam int DEFAULT_WAIT_CYCLES = 2;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised storage, per-lane synchronous write, combinational read
module dmem_array
   import pipe_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic [IDX_W-1:0]      idx,
   input  logic [WORD_BYTES-1:0] laneWe,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [DEPTH_WORDS];
   // update only the enabled byte lanes of the addressed word
   always_ff @(posedge clk)
      for (int i = 0; i < WORD_BYTES; i++)
         if (laneWe[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
   assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data memory with done/err handshake; DMEM_BYTE_EN_EN honours byte enables
module data_mem_responder
   import pipe_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        done,
   output logic        err,
   output logic        stall
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   memState_t state, stateNext;
   logic [3:0] cnt, cntNext;
   logic accept, cWe, cMis;
   logic [IDX_W-1:0] cIdx;
   logic [31:0] cWdata, rdataQ, arrRdata;
   logic [WORD_BYTES-1:0] laneWe, lanes;
   logic unusedBits;
`ifdef DMEM_BYTE_EN_EN
   logic [3:0] cBe;
   assign lanes = cBe;
   assign unusedBits = ^addr[31:IDX_W+2];
`else
   assign lanes = 4'hF;
   assign unusedBits = ^{addr[31:IDX_W+2], be};
`endif
   // next state, counter and handshake outputs
   always_comb begin
      stateNext = state;
      cntNext = cnt;
      accept = 1'b0;
      if (state == IDLE) begin
         accept = req;
         if (req) begin
            stateNext = (WAIT_CYCLES > 0) ? WAIT : RESP;
            cntNext = 4'(WAIT_CYCLES);
         end
      end else if (state == WAIT) begin
         cntNext = cnt - 4'd1;
         if (cnt == 4'd1) stateNext = RESP;
      end else begin
         stateNext = IDLE;
      end
      done = state == RESP;
      err = done && cMis;
      stall = req && !done;
      laneWe = (done && cWe && !cMis) ? lanes : '0;
      rdata = (done && !cWe && !cMis) ? arrRdata : rdataQ;
   end
   // state and wait counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= stateNext;
         cnt <= cntNext;
      end
   // capture the accepted request and retain the last completed read
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cWe <= 1'b0;
         cMis <= 1'b0;
         cIdx <= '0;
         cWdata <= '0;
         rdataQ <= '0;
`ifdef DMEM_BYTE_EN_EN
         cBe <= '0;
`endif
      end else begin
         if (accept) begin
            cWe <= we;
            cMis <= |addr[1:0];
            cIdx <= addr[2 +: IDX_W];
            cWdata <= wdata;
`ifdef DMEM_BYTE_EN_EN
            cBe <= be;
`endif
         end
         if (done) rdataQ <= rdata;
      end
   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) uArray (
      .clk(clk),
      .idx(cIdx),
      .laneWe(laneWe),
      .wdata(cWdata),
      .rdata(arrRdata)
   );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random transactions checked against a word-array reference model
module tb_data_mem_responder;
   localparam int W = 2;
   localparam int D = 256;
   logic clk = 1'b0;
   logic rst, req, we, done, err, stall;
   logic [31:0] addr, wdata, rdata;
   logic [3:0] be;
   int total = 0;
   int bad = 0;
   logic [31:0] model [D];
   logic [31:0] lastRd;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .be(be), .rdata(rdata), .done(done), .err(err), .stall(stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
      logic [31:0] r;
      r = old;
`ifdef DMEM_BYTE_EN_EN
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
`else
      r = d;
      if (b == 4'hx) r = old;
`endif
      return r;
   endfunction

   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input bit drop);
      int lat, st, idx;
      bit mis;
      mis = (a % 4) != 0;
      idx = int'((a / 4) % D);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      #1 st = int'(stall);
      lat = 0;
      @(posedge clk); #1;
      if (drop) req = 1'b0;
      we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
      do begin
         @(negedge clk);
         lat++;
         if (!done) st += int'(stall);
      end while (!done && lat < 20);
      check("latency", lat, W + 1);
      check("done", done, 1);
      check("err", err, mis);
      check("stall_resp", stall, 0);
      if (!w && !mis) lastRd = model[idx];
      check("rdata", rdata, lastRd);
      if (!drop) check("stall_cycles", st, W + 1);
      if (w && !mis) model[idx] = merge(model[idx], d, b);
      @(posedge clk); #1;
      req = 1'b0;
      check("done_idle", done, 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      lastRd = '0;
   endtask

   task automatic abortWrite(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = 4'hF;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      check("abort_wait_done", done, 0);
      rst = 1'b1;
      #1 check("abort_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      lastRd = '0;
      repeat (W + 3) begin
         @(negedge clk);
         check("abort_quiet", done, 0);
      end
      check("abort_rdata", rdata, 0);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      lastRd = '0;
      repeat (2) @(negedge clk);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_rdata", rdata, 0);
      check("reset_stall", stall, 0);
      rst = 1'b0;
      for (int i = 0; i < D; i++) model[i] = '0;
      for (int i = 0; i < D; i++) txn(1'b1, 32'(i * 4), 32'h0, 4'hF, 1'b0);
      doReset();
      txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      check("read0", rdata, 32'h0000_0000);
      txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      check("read10", rdata, 32'hDEAD_BEEF);
      txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0);
      txn(1'b1, 32'h20, 32'hAAAA_AAAA, 4'b0010, 1'b0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
`ifdef DMEM_BYTE_EN_EN
      check("lane_merge", rdata, 32'h1122_AA44);
`else
      check("lane_merge", rdata, 32'hAAAA_AAAA);
`endif
      txn(1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
      check("misaligned_hold", rdata, 32'h1122_AA44 & 32'h0 | lastRd);
      txn(1'b1, 32'h11, 32'h0, 4'hF, 1'b0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      check("misaligned_nowrite", rdata, 32'hDEAD_BEEF);
      txn(1'b1, 32'h400, 32'h5, 4'hF, 1'b0);
      txn(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      check("wrap", rdata, 32'h0000_0005);
      txn(1'b1, 32'h30, 32'h1234_5678, 4'hF, 1'b0);
      abortWrite(32'h30, 32'hCAFE_F00D);
      txn(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
      check("abort_kept", rdata, 32'h1234_5678);
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = ($urandom << 10) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
         txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, memory depth in 32-bit words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  memory-stage access request.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  write data.
REQ-009 be  input  4  byte enables, bit i = byte lane i (wdata[8i+7:8i]).
REQ-010 rdata  output  32  read data.
REQ-011 done  output  1  one-cycle pulse marking transaction completion.
REQ-012 err  output  1  misaligned-access flag, valid with done.
REQ-013 stall  output  1  pipeline stall request to hazard logic.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 IDLE with req=1: the block SHALL capture we/addr/wdata/be, load the wait counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-016 WAIT: counter decrements each cycle; the FSM SHALL move to RESP on the cycle the counter reaches 0.
REQ-017 RESP: done=1 for exactly one cycle; the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: done SHALL assert exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 Captured write: array write SHALL occur on the RESP-exit edge, only to enabled lanes.
REQ-020 Captured read: rdata SHALL present the word at captured address during the RESP cycle and hold it until the next completed read.
REQ-021 Word index SHALL be addr[2 +: log2(DEPTH_WORDS)]; higher address bits ignored (wrap modulo depth).
REQ-022 addr[1:0] != 0: no array access, rdata unchanged, err=1 coincident with done.
REQ-023 stall SHALL equal req AND NOT done (combinational).
REQ-024 req high during RESP SHALL NOT start a transaction; next request is accepted in the following IDLE cycle.
REQ-025 req dropped during WAIT/RESP: the captured transaction SHALL still complete (including write).
REQ-026 Inputs changing after capture SHALL NOT affect the in-flight transaction.

Reset
REQ-027 rst SHALL force IDLE, counter 0, done=0, err=0, rdata=0, captured registers 0.
REQ-028 rst mid-transaction SHALL abort it with no array write; array contents SHALL NOT be cleared.

Configuration
REQ-029 Macro DMEM_BYTE_EN_EN defined: be honoured per REQ-019.
REQ-030 Macro DMEM_BYTE_EN_EN undefined: be ignored, every write updates all four lanes.

Structure
REQ-031 Shared package pipe_mem_pkg SHALL hold the FSM state enum, WORD_BYTES=4, and the default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-032 Storage SHALL be a sub-module dmem_array (synchronous write, combinational read, lane write enables); FSM and counter stay in data_mem_responder.

Verification
REQ-033 Reset, then read addr 0x0 with WAIT_CYCLES=2 -> done on third cycle after acceptance, rdata=0x00000000, err=0, stall high for 3 cycles.
REQ-034 Write 0xDEADBEEF to 0x10 (be=4'hF), then read 0x10 -> rdata=0xDEADBEEF.
REQ-035 With DMEM_BYTE_EN_EN: write 0x11223344 to 0x20, then 0xAAAAAAAA with be=4'b0010, read -> 0x1122AA44; without macro -> 0xAAAAAAAA.
REQ-036 Read addr 0x13 -> err=1 with done, rdata unchanged; write 0x0 to 0x11 -> no memory change.
REQ-037 DEPTH_WORDS=256: write 0x5 to 0x400, read 0x0 -> 0x00000005 (wrap).
REQ-038 Write 0xCAFEF00D to 0x30 in flight, assert rst during WAIT -> done never pulses, FSM IDLE; later read 0x30 -> prior contents, not 0xCAFEF00D.
